// File: rtl/es8388_init_ctrl_if.sv
// Write-engine and init-table bus for the ES8388 init sequencer.
// master = sequencer side, slave = I2C write engine / table ROM side.
interface es8388_init_ctrl_if;
  logic [7:0]  lut_addr;
  logic [15:0] lut_q;
  logic        wr_req;
  logic [7:0]  wr_dev_addr;
  logic [7:0]  wr_reg_addr;
  logic [7:0]  wr_data;
  logic        i2c_done;
  logic        i2c_ack_err;

  modport master (
    output lut_addr, wr_req, wr_dev_addr, wr_reg_addr, wr_data,
    input  lut_q, i2c_done, i2c_ack_err
  );

  modport slave (
    input  lut_addr, wr_req, wr_dev_addr, wr_reg_addr, wr_data,
    output lut_q, i2c_done, i2c_ack_err
  );
endinterface

// File: rtl/es8388_init_ctrl.sv
// Walks the ES8388 init table and issues one I2C register write per entry,
// with settle delays after soft reset / power-up and bounded retries on NACK.
//
// state | meaning
// PWRUP | wait for the codec to power up after reset release
// FETCH | table address = idx, ROM word arrives next cycle
// LATCH | capture table word and device id into the write registers
// REQ   | one-cycle wr_req pulse
// WAIT  | wait for i2c_done, with timeout
// POST  | pick settle delay from the written word
// DLY   | count down the settle delay
// NEXT  | advance to the next entry or finish
// DONE  | all entries written, terminal
// ERR   | an entry failed after all retries, terminal
module es8388_init_ctrl #(
  parameter int unsigned POWERUP_DLY_CYC  = 1_000_000,
  parameter int unsigned RESET_DLY_CYC    = 5_000_000,
  parameter int unsigned LONG_DLY_CYC     = 25_000_000,
  parameter int unsigned DONE_TIMEOUT_CYC = 100_000,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 dev_id,
  input  logic [7:0]                 lut_size,
  es8388_init_ctrl_if.master         bus,
  output logic                       init_done,
  output logic                       init_err
);

  localparam logic [31:0] PWRUP_LAST   = 32'(POWERUP_DLY_CYC - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(DONE_TIMEOUT_CYC - 1);
  localparam logic [31:0] RESET_DLY    = 32'(RESET_DLY_CYC);
  localparam logic [31:0] LONG_DLY     = 32'(LONG_DLY_CYC);
  localparam logic [7:0]  RETRY_MAX    = 8'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_PWRUP, S_FETCH, S_LATCH, S_REQ, S_WAIT,
    S_POST, S_DLY, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  retry_q, retry_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  dat_q, dat_d;
  logic [31:0] post_dly;
  logic [7:0]  idx_inc;

  assign idx_inc = idx_q + 8'd1;

  always_comb begin
    post_dly = 32'd0;
    if ({reg_q, dat_q} == 16'h0080)      post_dly = RESET_DLY;
    else if ({reg_q, dat_q} == 16'h0200) post_dly = LONG_DLY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PWRUP;
      idx_q   <= 8'd0;
      retry_q <= 8'd0;
      cnt_q   <= 32'd0;
      dev_q   <= 8'd0;
      reg_q   <= 8'd0;
      dat_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    dat_d   = dat_q;
    case (state_q)
      S_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          cnt_d   = 32'd0;
          state_d = (lut_size == 8'd0) ? S_DONE : S_FETCH;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        reg_d   = bus.lut_q[15:8];
        dat_d   = bus.lut_q[7:0];
        dev_d   = dev_id;
        state_d = S_REQ;
      end
      S_REQ: begin
        cnt_d   = 32'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i2c_done && !bus.i2c_ack_err) begin
          state_d = S_POST;
        end else if (bus.i2c_done || cnt_q == TIMEOUT_LAST) begin
          // a timeout is handled exactly like a NACK
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 8'd1;
            state_d = S_REQ;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_POST: begin
        if (post_dly == 32'd0) begin
          state_d = S_NEXT;
        end else begin
          cnt_d   = post_dly - 32'd1;
          state_d = S_DLY;
        end
      end
      S_DLY: begin
        if (cnt_q == 32'd0) state_d = S_NEXT;
        else                cnt_d   = cnt_q - 32'd1;
      end
      S_NEXT: begin
        retry_d = 8'd0;
        idx_d   = idx_inc;
        state_d = (idx_inc == lut_size) ? S_DONE : S_FETCH;
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_PWRUP;
    endcase
  end

  // idx only moves in NEXT, so it is already stable for the ROM during FETCH
  assign bus.lut_addr    = idx_q;
  assign bus.wr_req      = (state_q == S_REQ);
  assign bus.wr_dev_addr = dev_q;
  assign bus.wr_reg_addr = reg_q;
  assign bus.wr_data     = dat_q;
  assign init_done       = (state_q == S_DONE);
  assign init_err        = (state_q == S_ERR);

endmodule

// File: tb/tb_es8388_init_ctrl.sv
// Directed bench for es8388_init_ctrl: ROM with 1-cycle latency, I2C engine
// answering 30 cycles after wr_req, with per-entry NACK / drop injection.
module tb_es8388_init_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dev_id = 8'h20;
  logic [7:0] lut_size = 8'd0;
  logic       init_done, init_err;

  es8388_init_ctrl_if bus ();

  es8388_init_ctrl #(
    .POWERUP_DLY_CYC (10),
    .RESET_DLY_CYC   (20),
    .LONG_DLY_CYC    (50),
    .DONE_TIMEOUT_CYC(200),
    .MAX_RETRY       (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dev_id   (dev_id),
    .lut_size (lut_size),
    .bus      (bus.master),
    .init_done(init_done),
    .init_err (init_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] rom [0:255];
  always @(posedge clk) bus.lut_q <= rom[bus.lut_addr];

  int checks = 0;
  int failures = 0;

  int          nack_idx = -1, nack_times = 0, drop_idx = -1;
  int          attempts [256];
  int          n_req = 0, n_done = 0, viol = 0;
  int          req_cyc  [64];
  logic [23:0] req_word [64];
  int          done_cyc [64];
  int          done_rise = -1, err_rise = -1;
  logic        pending = 1'b0;
  logic        nack_now = 1'b0;
  int          due = 0;
  logic [23:0] held = '0;
  int          exp_idx [64];
  int          exp_n = 0;

  // I2C engine model and write-bus monitor, all on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      pending         = 1'b0;
      bus.i2c_done    = 1'b0;
      bus.i2c_ack_err = 1'b0;
    end else begin
      if (bus.i2c_done) begin
        bus.i2c_done    = 1'b0;
        bus.i2c_ack_err = 1'b0;
        pending         = 1'b0;
      end
      if (bus.wr_req) begin
        if (pending) viol++;
        if (n_req < 64) begin
          req_cyc[n_req]  = cyc;
          req_word[n_req] = {bus.wr_dev_addr, bus.wr_reg_addr, bus.wr_data};
        end
        n_req++;
        held = {bus.wr_dev_addr, bus.wr_reg_addr, bus.wr_data};
        if (int'(bus.lut_addr) == drop_idx) begin
          pending = 1'b0;
        end else begin
          pending  = 1'b1;
          due      = cyc + 30;
          nack_now = (int'(bus.lut_addr) == nack_idx) && (attempts[bus.lut_addr] < nack_times);
        end
        attempts[bus.lut_addr]++;
      end else if (pending && held !== {bus.wr_dev_addr, bus.wr_reg_addr, bus.wr_data}) begin
        viol++;
      end
      if (pending && cyc == due) begin
        bus.i2c_done    = 1'b1;
        bus.i2c_ack_err = nack_now;
        if (n_done < 64) done_cyc[n_done] = cyc;
        n_done++;
      end
      if (init_done && done_rise < 0) done_rise = cyc;
      if (init_err && err_rise < 0)   err_rise  = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dly_of(input logic [15:0] w);
    if (w == 16'h0080) return 20;
    if (w == 16'h0200) return 50;
    return 0;
  endfunction

  task automatic start(input logic [7:0] size, input int nidx, input int ntimes, input int didx);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_outputs",
             32'({bus.wr_req, init_done, init_err, bus.lut_addr,
                  bus.wr_dev_addr, bus.wr_reg_addr, bus.wr_data}), 32'd0);
    repeat (3) @(negedge clk);
    nack_idx = nidx; nack_times = ntimes; drop_idx = didx;
    for (int i = 0; i < 256; i++) attempts[i] = 0;
    n_req = 0; n_done = 0; viol = 0; done_rise = -1; err_rise = -1;
    exp_n = 0;
    lut_size = size;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      exp_idx[exp_n] = i;
      exp_n++;
    end
  endtask

  task automatic wait_end(input string tag, input int budget);
    int i = 0;
    while (!(init_done || init_err) && i < budget) begin
      @(posedge clk);
      #1 i++;
    end
    check({tag, "_finished_in_time"}, 32'(i < budget), 32'd1);
    repeat (300) @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_req_count"}, 32'(n_req), 32'(exp_n));
    for (int k = 0; k < exp_n && k < n_req && k < 64; k++)
      check($sformatf("%s_req%0d_word", tag, k), 32'(req_word[k]),
            32'({8'h20, rom[exp_idx[k]]}));
    check({tag, "_no_overlap_or_change"}, 32'(viol), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {8'(i + 3), 8'(i * 7)};
    rom[0] = 16'h0080;
    rom[6] = 16'h0200;

    // 1+2) full table, clean ACKs, delay gaps
    start(8'd43, -1, 0, -1);
    wait_end("s1", 4000);
    push_range(0, 42);
    check_seq("s1");
    check("s1_init_done", 32'(init_done), 32'd1);
    check("s1_init_err", 32'(init_err), 32'd0);
    check("s1_done_count", 32'(n_done), 32'd43);
    check("s1_gap_after_soft_reset", 32'(req_cyc[1] - done_cyc[0] - 1), 32'd24);
    check("s1_gap_after_powerup", 32'(req_cyc[7] - done_cyc[6] - 1), 32'd54);
    check("s1_gap_plain", 32'(req_cyc[2] - done_cyc[1] - 1), 32'd4);
    for (int k = 0; k < 42; k++)
      check($sformatf("s1_gap%0d", k), 32'(req_cyc[k + 1] - done_cyc[k] - 1),
            32'(4 + dly_of(rom[k])));
    check("s1_done_rise", 32'(done_rise), 32'(done_cyc[42] + 3));

    // 3) entry 5 NACKed twice
    start(8'd43, 5, 2, -1);
    wait_end("s3", 4000);
    push_range(0, 5); push_range(5, 5); push_range(5, 42);
    check_seq("s3");
    check("s3_init_done", 32'(init_done), 32'd1);
    check("s3_init_err", 32'(init_err), 32'd0);
    check("s3_retry_gap", 32'(req_cyc[6] - done_cyc[5]), 32'd1);

    // 4) entry 7 always NACKed
    start(8'd43, 7, 255, -1);
    wait_end("s4", 4000);
    push_range(0, 7); push_range(7, 7); push_range(7, 7); push_range(7, 7);
    check_seq("s4");
    check("s4_init_err", 32'(init_err), 32'd1);
    check("s4_init_done", 32'(init_done), 32'd0);
    check("s4_err_rise", 32'(err_rise), 32'(done_cyc[10] + 1));
    check("s4_retry_gap", 32'(req_cyc[8] - done_cyc[7]), 32'd1);

    // 5) entry 2 never answered
    start(8'd43, -1, 0, 2);
    wait_end("s5", 3000);
    push_range(0, 2); push_range(2, 2); push_range(2, 2); push_range(2, 2);
    check_seq("s5");
    check("s5_init_err", 32'(init_err), 32'd1);
    check("s5_init_done", 32'(init_done), 32'd0);
    check("s5_timeout_gap", 32'(req_cyc[3] - req_cyc[2]), 32'd201);
    check("s5_err_rise", 32'(err_rise), 32'(req_cyc[5] + 201));

    // 6a) empty table
    start(8'd0, -1, 0, -1);
    repeat (9) @(posedge clk);
    #1 check("s6_empty_not_yet_done", 32'(init_done), 32'd0);
    @(posedge clk);
    #1 check("s6_empty_done", 32'(init_done), 32'd1);
    repeat (50) @(posedge clk);
    #1 check("s6_empty_no_req", 32'(n_req), 32'd0);

    // 6b) reset during entry 10's WAIT, then a clean restart
    start(8'd43, -1, 0, -1);
    begin
      int i = 0;
      while (n_req < 11 && i < 2000) begin
        @(posedge clk);
        #1 i++;
      end
      check("s6_reached_entry10", 32'(i < 2000), 32'd1);
    end
    repeat (5) @(posedge clk);
    #1 check("s6_waiting_on_entry10", 32'(bus.lut_addr), 32'd10);
    start(8'd43, -1, 0, -1);
    wait_end("s6", 4000);
    push_range(0, 42);
    check_seq("s6");
    check("s6_init_done", 32'(init_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
